kpn_queue_write_arbiter: RTL
============================

// Module: kpn_queue_write_arbiter
// PURPOSE
//   Shares the single write port of one KPN channel queue (16-bit, 2**5-entry FIFO) among N producer processes.
//   Round-robin arbitration with bounded bursts.
//   KPN blocking-write semantics: a granted producer stalls while the queue is full. No token is dropped or duplicated.
//   Sits between the producer process modules and the queue write side (fifo_wr/fifo_data/fifo_full).
// PARAMETERS
//   BITS_NUMBER   16  token width, matches queue data width
//   N_REQ         4   number of producer processes (2..8)
//   ID_BITS       2   width of grant_id, = clog2(N_REQ)
//   MAX_BURST     4   max consecutive tokens per grant (1..15)
// PORTS
//   clk        in   1                  rising-edge clock
//   reset      in   1                  synchronous, active-high
//   req        in   N_REQ              req[i]=1: producer i presents a valid token
//   data_in    in   N_REQ*BITS_NUMBER  token of producer i at [i*BITS_NUMBER +: BITS_NUMBER]
//   fifo_full  in   1                  queue cannot accept a write this cycle
//   ack        out  N_REQ              one-hot, token i accepted this cycle
//   fifo_wr    out  1                  write strobe to queue
//   fifo_data  out  BITS_NUMBER        token to queue
//   grant_id   out  ID_BITS            currently granted producer (valid when busy)
//   busy       out  1                  1 while in GRANT state
// BEHAVIOUR
//   - Registers: state{IDLE,GRANT}, gid, last_gid, burst_cnt[3:0].
//   - Reset values: state=IDLE, gid=0, last_gid=N_REQ-1 (producer 0 has first priority), burst_cnt=0.
//   - Outputs during and after reset: ack=0, fifo_wr=0, busy=0, grant_id=0.
//   - fifo_data = data_in[gid] slice at all times. It is a don't-care unless fifo_wr=1.
//   - Accept condition (combinational): acc = (state==GRANT) & req[gid] & ~fifo_full.
//     fifo_wr = acc; ack = acc ? (1<<gid) : 0.
//   - Handshake: valid/ready. A producer holds req and data stable until it sees ack.
//     On the ack cycle it may present the next token or drop req.
//   - IDLE: if |req, gid <= first i with req[i]=1, searching from last_gid+1 modulo N_REQ; burst_cnt <= 0; state <= GRANT.
//     If req==0, stay in IDLE.
//   - Arbitration costs exactly one cycle. req asserted before edge k gives the earliest ack in the cycle after edge k.
//   - GRANT, acc=1 and burst_cnt==MAX_BURST-1: last_gid <= gid; state <= IDLE.
//   - GRANT, acc=1 otherwise: burst_cnt <= burst_cnt+1; stay.
//   - GRANT, req[gid]=0: last_gid <= gid; state <= IDLE; no write.
//   - GRANT, req[gid]=1 and fifo_full=1: blocked. Hold gid and burst_cnt; fifo_wr=0, ack=0. The wait is unbounded (KPN blocking write).
//   - Requests from other producers during GRANT are ignored until the return to IDLE. This means at least one idle cycle between grants.
//   - Simultaneous events: fifo_full has priority over the write. A req drop in the same cycle as fifo_full goes to IDLE without writing.
//   - Reset mid-burst: the next cycle is IDLE with all outputs 0. The in-flight token is not written. Priority restarts at producer 0.
//   - Requesters with index >= N_REQ do not exist; gid never exceeds N_REQ-1.
// TESTING
//   1 Reset, then req=4'b0001, data0=16'h00AA: one cycle later busy=1, grant_id=0, fifo_wr=1, fifo_data=16'h00AA, ack=4'b0001.
//   2 req=4'b1111 held, fifo_full=0, MAX_BURST=4: write order 0,0,0,0,-,1,1,1,1,-,2x4,-,3x4,-,0.
//     '-' is a cycle with fifo_wr=0. Exactly 4 acks per grant.
//   3 Grant to producer 2 (data 16'h1234), fifo_full=1 for 3 cycles: fifo_wr=0, ack=0, grant_id=2 held.
//     When full drops, 16'h1234 is written exactly once in that cycle.
//   4 Producer 1 granted, drops req after 2 acks while req[3]=1: next cycle IDLE, then grant_id=3.
//     Producer 2 is skipped because req[2]=0.
//   5 Reset asserted for one cycle during the 3rd token of a burst from producer 3: cycle after reset has busy=0, fifo_wr=0.
//     With all req set, the next grant goes to producer 0.
//   6 With the real 32-entry queue, 40 tokens from 2 producers: 32 written, then both blocked.
//     After the consumer reads 8 tokens, the remaining 8 are written in round-robin order. No loss or duplication, checked against a scoreboard.

Source files
------------

// File: rtl/kpn_queue_write_arbiter.sv
// kpn_queue_write_arbiter
//   Shares the single write port of one KPN channel queue among N_REQ producer
//   processes. Round-robin arbitration, bursts bounded to MAX_BURST tokens per
//   grant, and blocking-write semantics: a granted producer waits while the
//   queue is full, so no token is ever dropped or duplicated.
// Ports
//   clk, reset  rising-edge clock, synchronous active-high reset
//   req         per-producer token-valid
//   data_in     per-producer token, producer i at [i*BITS_NUMBER +: BITS_NUMBER]
//   fifo_full   queue cannot accept a write this cycle
//   ack         one-hot, token of the granted producer accepted this cycle
//   fifo_wr     write strobe to the queue
//   fifo_data   token of the granted producer (meaningful when fifo_wr=1)
//   grant_id    granted producer (meaningful when busy=1)
//   busy        a grant is active
module kpn_queue_write_arbiter #(
  parameter int unsigned BITS_NUMBER = 16,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_BITS     = 2,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*BITS_NUMBER-1:0] data_in,
  input  logic                         fifo_full,
  output logic [N_REQ-1:0]             ack,
  output logic                         fifo_wr,
  output logic [BITS_NUMBER-1:0]       fifo_data,
  output logic [ID_BITS-1:0]           grant_id,
  output logic                         busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state;
  logic [ID_BITS-1:0] gid;
  logic [ID_BITS-1:0] last_gid;
  logic [ID_BITS-1:0] nxt_gid;
  logic [CNT_W-1:0]   burst_cnt;
  logic               req_sel;
  logic               acc;
  int                 rr_dist;
  int                 rr_best;

  // Select request and token of the granted producer.
  always_comb begin
    req_sel   = 1'b0;
    fifo_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gid == ID_BITS'(i)) begin
        req_sel   = req[i];
        fifo_data = data_in[i*BITS_NUMBER +: BITS_NUMBER];
      end
    end
  end

  // Accept: full blocks the write; reset suppresses any in-flight token.
  always_comb begin
    acc = ~reset & (state == GRANT) & req_sel & ~fifo_full;
    fifo_wr = acc;
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = acc & (gid == ID_BITS'(i));
    end
    busy     = ~reset & (state == GRANT);
    grant_id = reset ? '0 : gid;
  end

  // Round-robin pick: smallest distance after last_gid among requesters.
  always_comb begin
    nxt_gid = '0;
    rr_best = int'(N_REQ);
    rr_dist = 0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_dist = int'((32'(i) + 2 * N_REQ - 32'(last_gid) - 1) % N_REQ);
      if (req[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        nxt_gid = ID_BITS'(i);
      end
    end
  end

  // Grant state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gid       <= '0;
      last_gid  <= ID_BITS'(N_REQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gid       <= nxt_gid;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!req_sel) begin
            last_gid <= gid;
            state    <= IDLE;
          end else if (!fifo_full) begin
            if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
              last_gid <= gid;
              state    <= IDLE;
            end else begin
              burst_cnt <= burst_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
